// File: rtl/mcb_port_arb_pkg.sv
// Shared definitions for the MCB port arbiter: widths, MCB instruction codes, FSM states.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package mcb_port_arb_pkg;

   localparam int DATA_W = 64;
   localparam int MASK_W = 8;
   localparam int BL_W   = 6;
   localparam int ADDR_W = 30;
   localparam int CNT_W  = 7;

   localparam logic [2:0] INSTR_WR = 3'b000;
   localparam logic [2:0] INSTR_RD = 3'b001;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_DATA = 3'd1,
      ST_WR_CMD  = 3'd2,
      ST_RD_CMD  = 3'd3,
      ST_RD_DATA = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   // MCB bursts are 64-bit aligned, so the low three byte-address bits are dropped.
   function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
      return a & {{(ADDR_W-3){1'b1}}, 3'b000};
   endfunction

endpackage

// File: rtl/mcb_rr_pick.sv
// Two-request round-robin picker: the client not served last wins a tie.
// Latency: purely combinational.
// Backpressure: none; valid is simply the OR of the requests.
module mcb_rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner,
   output logic       valid
);

   // Tie goes to the client that was not served last; otherwise the sole requester.
   always_comb begin
      valid  = |req;
      winner = 1'b0;
      if (req == 2'b11) begin
         winner = ~last;
      end else if (req[1]) begin
         winner = 1'b1;
      end
   end

endmodule

// File: rtl/mcb_port_arb.sv
// Two-client sequencer for one MCB user port; serves one whole burst at a time, round-robin.
// Latency: grant one cycle after req; write = bl+1 data + 1 cmd + 1 done cycle; read = 1 cmd + data + 1 done.
// Backpressure: MCB full/empty holds state and counters; NCLK_TO consecutive stall cycles force DONE and set err_out.
module mcb_port_arb
   import mcb_port_arb_pkg::*;
#(
   parameter int NCLK_TO = 1024
) (
   input  logic              clk,
   input  logic              rst,
   // client 0 (Ethernet receive)
   input  logic              c0_req_in,
   input  logic              c0_we_in,
   input  logic [ADDR_W-1:0] c0_addr_in,
   input  logic [BL_W-1:0]   c0_bl_in,
   output logic              c0_gnt_out,
   input  logic [DATA_W-1:0] c0_wr_data_in,
   input  logic [MASK_W-1:0] c0_wr_mask_in,
   output logic              c0_wr_next_out,
   output logic [DATA_W-1:0] c0_rd_data_out,
   output logic              c0_rd_valid_out,
   output logic              c0_done_out,
   // client 1 (framebuffer fetch)
   input  logic              c1_req_in,
   input  logic              c1_we_in,
   input  logic [ADDR_W-1:0] c1_addr_in,
   input  logic [BL_W-1:0]   c1_bl_in,
   output logic              c1_gnt_out,
   input  logic [DATA_W-1:0] c1_wr_data_in,
   input  logic [MASK_W-1:0] c1_wr_mask_in,
   output logic              c1_wr_next_out,
   output logic [DATA_W-1:0] c1_rd_data_out,
   output logic              c1_rd_valid_out,
   output logic              c1_done_out,
   // MCB command port
   output logic              mcb_cmd_en_out,
   output logic [2:0]        mcb_cmd_instr_out,
   output logic [BL_W-1:0]   mcb_cmd_bl_out,
   output logic [ADDR_W-1:0] mcb_cmd_byte_addr_out,
   input  logic              mcb_cmd_full_in,
   // MCB write port
   output logic              mcb_wr_en_out,
   output logic [MASK_W-1:0] mcb_wr_mask_out,
   output logic [DATA_W-1:0] mcb_wr_data_out,
   input  logic              mcb_wr_full_in,
   input  logic              mcb_wr_error_in,
   input  logic              mcb_wr_underrun_in,
   // MCB read port
   output logic              mcb_rd_en_out,
   input  logic [DATA_W-1:0] mcb_rd_data_in,
   input  logic              mcb_rd_empty_in,
   input  logic              mcb_rd_error_in,
   input  logic              mcb_rd_overflow_in,
   output logic              err_out
);

   localparam int SW = $clog2(NCLK_TO + 1);

   state_t            state, state_nxt;
   logic              sel;        // granted client
   logic              last;       // client served most recently
   logic [ADDR_W-1:0] addr_q;
   logic [BL_W-1:0]   bl_q;
   logic [CNT_W-1:0]  wcnt;
   logic [SW-1:0]     stall_cnt;
   logic              err;
   logic              pick_winner, pick_valid;
   logic              accept, stalled, timeout, last_word;

   mcb_rr_pick u_pick (
      .req    ({c1_req_in, c0_req_in}),
      .last   (last),
      .winner (pick_winner),
      .valid  (pick_valid)
   );

   assign last_word = (wcnt == {1'b0, bl_q});

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and MCB-side strobes; each data/cmd state stalls on its own full/empty flag.
   always_comb begin
      state_nxt             = state;
      accept                = 1'b0;
      stalled               = 1'b0;
      timeout               = 1'b0;
      mcb_cmd_en_out        = 1'b0;
      mcb_cmd_instr_out     = 3'b000;
      mcb_cmd_bl_out        = '0;
      mcb_cmd_byte_addr_out = '0;
      mcb_wr_en_out         = 1'b0;
      mcb_wr_mask_out       = '0;
      mcb_wr_data_out       = '0;
      mcb_rd_en_out         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               state_nxt = (pick_winner ? c1_we_in : c0_we_in) ? ST_WR_DATA : ST_RD_CMD;
            end
         end
         ST_WR_DATA: begin
            accept          = !mcb_wr_full_in;
            stalled         = mcb_wr_full_in;
            mcb_wr_en_out   = accept;
            mcb_wr_data_out = sel ? c1_wr_data_in : c0_wr_data_in;
            mcb_wr_mask_out = sel ? c1_wr_mask_in : c0_wr_mask_in;
            if (accept && last_word) state_nxt = ST_WR_CMD;
         end
         ST_WR_CMD, ST_RD_CMD: begin
            stalled               = mcb_cmd_full_in;
            mcb_cmd_en_out        = !mcb_cmd_full_in;
            mcb_cmd_instr_out     = (state == ST_WR_CMD) ? INSTR_WR : INSTR_RD;
            mcb_cmd_bl_out        = bl_q;
            mcb_cmd_byte_addr_out = addr_q;
            if (!mcb_cmd_full_in) state_nxt = (state == ST_WR_CMD) ? ST_DONE : ST_RD_DATA;
         end
         ST_RD_DATA: begin
            accept        = !mcb_rd_empty_in;
            stalled       = mcb_rd_empty_in;
            mcb_rd_en_out = accept;
            if (accept && last_word) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      timeout = stalled && (stall_cnt == SW'(NCLK_TO - 1));
      if (timeout) state_nxt = ST_DONE;
   end

   // Transaction context, word/stall counters, fairness pointer and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel       <= 1'b0;
         last      <= 1'b1;
         addr_q    <= '0;
         bl_q      <= '0;
         wcnt      <= '0;
         stall_cnt <= '0;
         err       <= 1'b0;
      end else begin
         if (state == ST_IDLE && pick_valid) begin
            sel    <= pick_winner;
            addr_q <= align_addr(pick_winner ? c1_addr_in : c0_addr_in);
            bl_q   <= pick_winner ? c1_bl_in : c0_bl_in;
         end
         if (state != state_nxt) begin
            wcnt <= '0;
         end else if (accept) begin
            wcnt <= wcnt + 1'b1;
         end
         if (stalled && !timeout) begin
            stall_cnt <= stall_cnt + 1'b1;
         end else begin
            stall_cnt <= '0;
         end
         if (state == ST_DONE) last <= sel;
         err <= err | mcb_wr_error_in | mcb_wr_underrun_in | mcb_rd_error_in
                    | mcb_rd_overflow_in | timeout;
      end
   end

   assign err_out = err;

   // Client-side views: everything is zero for the client that does not hold the grant.
   assign c0_gnt_out      = (state != ST_IDLE) && !sel;
   assign c1_gnt_out      = (state != ST_IDLE) && sel;
   assign c0_wr_next_out  = mcb_wr_en_out && !sel;
   assign c1_wr_next_out  = mcb_wr_en_out && sel;
   assign c0_rd_valid_out = mcb_rd_en_out && !sel;
   assign c1_rd_valid_out = mcb_rd_en_out && sel;
   assign c0_rd_data_out  = c0_rd_valid_out ? mcb_rd_data_in : '0;
   assign c1_rd_data_out  = c1_rd_valid_out ? mcb_rd_data_in : '0;
   assign c0_done_out     = (state == ST_DONE) && !sel;
   assign c1_done_out     = (state == ST_DONE) && sel;

endmodule

// File: tb/tb_mcb_port_arb.sv
// Directed bench for mcb_port_arb: write, read, fairness, write stall, read timeout, mid-burst reset.
// Latency: n/a (bench).
// Backpressure: MCB full/empty driven per test from the stimulus loop.
module tb_mcb_port_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        c0_req_in = 0, c0_we_in = 0, c1_req_in = 0, c1_we_in = 0;
   logic [29:0] c0_addr_in = '0, c1_addr_in = '0;
   logic [5:0]  c0_bl_in = '0, c1_bl_in = '0;
   logic [63:0] c0_wr_data_in, c1_wr_data_in;
   logic [7:0]  c0_wr_mask_in, c1_wr_mask_in;
   logic        c0_gnt_out, c0_wr_next_out, c0_rd_valid_out, c0_done_out;
   logic        c1_gnt_out, c1_wr_next_out, c1_rd_valid_out, c1_done_out;
   logic [63:0] c0_rd_data_out, c1_rd_data_out;
   logic        mcb_cmd_en_out, mcb_cmd_full_in = 0;
   logic [2:0]  mcb_cmd_instr_out;
   logic [5:0]  mcb_cmd_bl_out;
   logic [29:0] mcb_cmd_byte_addr_out;
   logic        mcb_wr_en_out, mcb_wr_full_in = 0, mcb_wr_error_in = 0, mcb_wr_underrun_in = 0;
   logic [7:0]  mcb_wr_mask_out;
   logic [63:0] mcb_wr_data_out, mcb_rd_data_in;
   logic        mcb_rd_en_out, mcb_rd_empty_in = 0, mcb_rd_error_in = 0, mcb_rd_overflow_in = 0;
   logic        err_out;

   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   int c0_idx = 0, c1_idx = 0, rd_idx = 0;
   int dn0 = 0, dn1 = 0, total_done = 0, done0_cyc = 0, done1_cyc = 0;
   int cmd_cnt = 0, cmd_words = 0, err_cyc = -1;
   logic [2:0]  cmd_instr;
   logic [29:0] cmd_addr;
   logic [5:0]  cmd_bl;
   logic [63:0] wq[$], r0q[$], r1q[$];
   logic [7:0]  mq[$];
   int          dq[$];

   mcb_port_arb #(.NCLK_TO(16)) dut (
      .clk(clk), .rst(rst),
      .c0_req_in(c0_req_in), .c0_we_in(c0_we_in), .c0_addr_in(c0_addr_in), .c0_bl_in(c0_bl_in),
      .c0_gnt_out(c0_gnt_out), .c0_wr_data_in(c0_wr_data_in), .c0_wr_mask_in(c0_wr_mask_in),
      .c0_wr_next_out(c0_wr_next_out), .c0_rd_data_out(c0_rd_data_out),
      .c0_rd_valid_out(c0_rd_valid_out), .c0_done_out(c0_done_out),
      .c1_req_in(c1_req_in), .c1_we_in(c1_we_in), .c1_addr_in(c1_addr_in), .c1_bl_in(c1_bl_in),
      .c1_gnt_out(c1_gnt_out), .c1_wr_data_in(c1_wr_data_in), .c1_wr_mask_in(c1_wr_mask_in),
      .c1_wr_next_out(c1_wr_next_out), .c1_rd_data_out(c1_rd_data_out),
      .c1_rd_valid_out(c1_rd_valid_out), .c1_done_out(c1_done_out),
      .mcb_cmd_en_out(mcb_cmd_en_out), .mcb_cmd_instr_out(mcb_cmd_instr_out),
      .mcb_cmd_bl_out(mcb_cmd_bl_out), .mcb_cmd_byte_addr_out(mcb_cmd_byte_addr_out),
      .mcb_cmd_full_in(mcb_cmd_full_in),
      .mcb_wr_en_out(mcb_wr_en_out), .mcb_wr_mask_out(mcb_wr_mask_out),
      .mcb_wr_data_out(mcb_wr_data_out), .mcb_wr_full_in(mcb_wr_full_in),
      .mcb_wr_error_in(mcb_wr_error_in), .mcb_wr_underrun_in(mcb_wr_underrun_in),
      .mcb_rd_en_out(mcb_rd_en_out), .mcb_rd_data_in(mcb_rd_data_in),
      .mcb_rd_empty_in(mcb_rd_empty_in), .mcb_rd_error_in(mcb_rd_error_in),
      .mcb_rd_overflow_in(mcb_rd_overflow_in), .err_out(err_out)
   );

   always #5 clk = ~clk;

   // FWFT client sources and MCB read FIFO: word value encodes its sequence number.
   assign c0_wr_data_in  = {32'hC0DE0000, 32'(c0_idx)};
   assign c1_wr_data_in  = {32'hC1DE0000, 32'(c1_idx)};
   assign c0_wr_mask_in  = 8'h5A;
   assign c1_wr_mask_in  = 8'hA5;
   assign mcb_rd_data_in = {32'hBEEF0000, 32'(rd_idx)};

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (c0_wr_next_out) c0_idx <= c0_idx + 1;
      if (c1_wr_next_out) c1_idx <= c1_idx + 1;
      if (mcb_rd_en_out) rd_idx <= rd_idx + 1;
   end

   // Observe outputs mid-cycle.
   always @(negedge clk) begin
      if (mcb_wr_en_out) begin
         wq.push_back(mcb_wr_data_out);
         mq.push_back(mcb_wr_mask_out);
      end
      if (mcb_cmd_en_out) begin
         cmd_cnt++;
         cmd_instr = mcb_cmd_instr_out;
         cmd_addr  = mcb_cmd_byte_addr_out;
         cmd_bl    = mcb_cmd_bl_out;
         cmd_words = wq.size();
      end
      if (c0_rd_valid_out) r0q.push_back(c0_rd_data_out);
      if (c1_rd_valid_out) r1q.push_back(c1_rd_data_out);
      if (c0_done_out) begin dn0++; done0_cyc = cyc; dq.push_back(0); total_done++; end
      if (c1_done_out) begin dn1++; done1_cyc = cyc; dq.push_back(1); total_done++; end
      if (err_out && err_cyc < 0) err_cyc = cyc;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ctl_vec();
      return 64'({c0_gnt_out, c1_gnt_out, c0_wr_next_out, c1_wr_next_out, c0_rd_valid_out,
                  c1_rd_valid_out, c0_done_out, c1_done_out, mcb_cmd_en_out, mcb_wr_en_out,
                  mcb_rd_en_out, err_out});
   endfunction

   function automatic logic [63:0] bus_or();
      return 64'(|{mcb_cmd_byte_addr_out, mcb_cmd_bl_out, mcb_cmd_instr_out, mcb_wr_data_out,
                   mcb_wr_mask_out, c0_rd_data_out, c1_rd_data_out});
   endfunction

   // Step cycles until k more done pulses; mode 1 toggles rd_empty, mode 2 holds wr_full for 10 cycles.
   task automatic run(input string tag, input int k, input int limit, input int mode, input bit drop);
      int d0, d1, target;
      bit got;
      d0 = dn0; d1 = dn1; target = total_done + k; got = 0;
      for (int i = 1; i <= limit && !got; i++) begin
         @(posedge clk); #1;
         if (mode == 1) mcb_rd_empty_in = ~mcb_rd_empty_in;
         if (mode == 2) mcb_wr_full_in = (i >= 3 && i < 13);
         if (drop && dn0 != d0) c0_req_in = 0;
         if (drop && dn1 != d1) c1_req_in = 0;
         if (total_done >= target) got = 1;
      end
      mcb_wr_full_in = 0;
      check({tag, "_done_seen"}, 64'(got), 64'd1);
   endtask

   function automatic void clear_obs();
      wq.delete(); mq.delete(); r0q.delete(); r1q.delete(); dq.delete();
      cmd_cnt = 0; cmd_words = 0;
   endfunction

   initial begin
      int t0, base;
      // reset
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check("rst_ctl", ctl_vec(), 64'd0);
      check("rst_bus", bus_or(), 64'd0);

      // client 0 write, bl=3, no backpressure
      @(posedge clk); #1;
      clear_obs();
      c0_req_in = 1; c0_we_in = 1; c0_addr_in = 30'h0000_1234; c0_bl_in = 6'd3;
      t0 = cyc;
      @(negedge clk);
      check("wr_gnt_not_yet", 64'(c0_gnt_out), 64'd0);
      run("wr", 1, 40, 0, 1);
      check("wr_words", 64'(wq.size()), 64'd4);
      for (int i = 0; i < 4; i++) check($sformatf("wr_word%0d", i), wq[i], {32'hC0DE0000, 32'(i)});
      check("wr_mask", 64'(mq[0]), 64'h5A);
      check("wr_cmd_cnt", 64'(cmd_cnt), 64'd1);
      check("wr_cmd_after_data", 64'(cmd_words), 64'd4);
      check("wr_instr", 64'(cmd_instr), 64'd0);
      check("wr_addr", 64'(cmd_addr), 64'h1230);
      check("wr_bl", 64'(cmd_bl), 64'd3);
      check("wr_done_cycle", 64'(done0_cyc - t0), 64'd6);

      // client 1 read, bl=7, rd_empty toggling
      clear_obs();
      mcb_rd_empty_in = 0;
      c1_req_in = 1; c1_we_in = 0; c1_addr_in = 30'h0000_8008; c1_bl_in = 6'd7;
      run("rd", 1, 80, 1, 1);
      check("rd_count", 64'(r1q.size()), 64'd8);
      for (int i = 0; i < 8; i++) check($sformatf("rd_word%0d", i), r1q[i], {32'hBEEF0000, 32'(i)});
      check("rd_other_client_quiet", 64'(r0q.size()), 64'd0);
      check("rd_instr", 64'(cmd_instr), 64'd1);
      check("rd_addr", 64'(cmd_addr), 64'h8008);

      // both clients request continuously: reads, bl=1
      clear_obs();
      mcb_rd_empty_in = 0;
      c0_req_in = 1; c0_we_in = 0; c0_bl_in = 6'd1;
      c1_req_in = 1; c1_we_in = 0; c1_bl_in = 6'd1;
      run("rr", 4, 80, 0, 0);
      c0_req_in = 0; c1_req_in = 0;
      for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), 64'(dq[i]), 64'(i % 2));
      check("rr_c0_words", 64'(r0q.size()), 64'd4);
      check("rr_c1_words", 64'(r1q.size()), 64'd4);

      // write with wr_full held 10 cycles mid-burst
      @(posedge clk); #1;
      clear_obs();
      base = c0_idx;
      c0_req_in = 1; c0_we_in = 1; c0_addr_in = 30'h0000_0100; c0_bl_in = 6'd7;
      t0 = cyc;
      run("stall", 1, 60, 2, 1);
      check("stall_words", 64'(wq.size()), 64'd8);
      for (int i = 0; i < 8; i++)
         check($sformatf("stall_word%0d", i), wq[i], {32'hC0DE0000, 32'(base + i)});
      check("stall_cmd_after_last", 64'(cmd_words), 64'd8);
      check("stall_done_cycle", 64'(done0_cyc - t0), 64'd20);
      check("stall_no_err", 64'(err_out), 64'd0);

      // read timeout: rd_empty stuck high, NCLK_TO=16; client 0 waits behind it
      @(posedge clk); #1;
      clear_obs();
      err_cyc = -1;
      mcb_rd_empty_in = 1;
      c1_req_in = 1; c1_we_in = 0; c1_bl_in = 6'd3;
      c0_req_in = 1; c0_we_in = 1; c0_bl_in = 6'd0;
      t0 = cyc;
      run("to", 2, 100, 0, 1);
      check("to_done_cycle", 64'(done1_cyc - t0), 64'd18);
      check("to_err_cycle", 64'(err_cyc - t0), 64'd18);
      check("to_no_reads", 64'(r1q.size()), 64'd0);
      check("to_first", 64'(dq[0]), 64'd1);
      check("to_next_other", 64'(dq[1]), 64'd0);
      check("to_err_sticky", 64'(err_out), 64'd1);

      // reset during RD_DATA
      @(posedge clk); #1;
      c1_req_in = 1; c1_we_in = 0; c1_bl_in = 6'd7;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rstmid_in_rd", 64'({c1_gnt_out, mcb_cmd_en_out}), 64'b10);
      @(posedge clk); #1;
      rst = 1; c1_req_in = 0;
      @(posedge clk); #1;
      rst = 0;
      c0_req_in = 1; c0_we_in = 1; c0_bl_in = 6'd0;
      @(negedge clk);
      check("rstmid_ctl", ctl_vec(), 64'd0);
      check("rstmid_bus", bus_or(), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rstmid_gnt", 64'({c0_gnt_out, c1_gnt_out}), 64'b10);
      run("rstmid", 1, 20, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
